// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared L1 cache-controller encodings. Holds the MESI block
//                state codes, the bus snoop request ops (SUREQ_*), the snoop
//                responses (SDRSP_*), the snoop handler FSM state enum and a
//                small helper for the reserved op code.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

   // Block state codes as stored in the array.
   localparam logic [2:0] INVALID   = 3'd0;
   localparam logic [2:0] SHARED    = 3'd1;
   localparam logic [2:0] EXCLUSIVE = 3'd2;
   localparam logic [2:0] MODIFIED  = 3'd3;

   // Snoop request ops issued by the bus.
   localparam logic [1:0] SUREQ_RD   = 2'd0;
   localparam logic [1:0] SUREQ_RFO  = 2'd1;
   localparam logic [1:0] SUREQ_INV  = 2'd2;
   localparam logic [1:0] SUREQ_RSVD = 2'd3;

   // Snoop responses returned to the bus.
   localparam logic [1:0] SDRSP_OKAY = 2'd0;
   localparam logic [1:0] SDRSP_INV  = 2'd1;

   // Snoop handler control FSM.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_CMP  = 2'd2,
      ST_RSP  = 2'd3
   } snp_hdl_st_e;

   function automatic logic op_is_rsvd(input logic [1:0] op);
      return (op == SUREQ_RSVD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/snp_req_handler_if.sv
`default_nettype none
// ============================================================================
//  Module      : snp_req_handler_if
//  Description : Bus and array signals of the snoop request handler.
//                slave  modport : handler side (snp_req_handler)
//                master modport : bus / array side (environment)
//                Groups: snoop request (valid/ready/op/addr), blk_lock,
//                array read (rd_en/idx/rd_tag/rd_st/rd_data), array state
//                write (wr_st_en/wr_st), snoop response (valid/ready/rsp/
//                dirty/data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface snp_req_handler_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int IDX_WIDTH  = 6
);
   localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);
   localparam int TAG_WIDTH = ADDR_WIDTH - IDX_WIDTH - OFF_WIDTH;

   logic                  snp_req_valid;
   logic                  snp_req_ready;
   logic [1:0]            snp_req_op;
   logic [ADDR_WIDTH-1:0] snp_req_addr;
   logic                  blk_lock;
   logic                  ary_rd_en;
   logic [IDX_WIDTH-1:0]  ary_idx;
   logic [TAG_WIDTH-1:0]  ary_rd_tag;
   logic [2:0]            ary_rd_st;
   logic [DATA_WIDTH-1:0] ary_rd_data;
   logic                  ary_wr_st_en;
   logic [2:0]            ary_wr_st;
   logic                  snp_rsp_valid;
   logic                  snp_rsp_ready;
   logic [1:0]            snp_rsp;
   logic                  snp_rsp_dirty;
   logic [DATA_WIDTH-1:0] snp_rsp_data;

   modport slave (
      input  snp_req_valid, snp_req_op, snp_req_addr, blk_lock,
      input  ary_rd_tag, ary_rd_st, ary_rd_data, snp_rsp_ready,
      output snp_req_ready, ary_rd_en, ary_idx, ary_wr_st_en, ary_wr_st,
      output snp_rsp_valid, snp_rsp, snp_rsp_dirty, snp_rsp_data
   );

   modport master (
      output snp_req_valid, snp_req_op, snp_req_addr, blk_lock,
      output ary_rd_tag, ary_rd_st, ary_rd_data, snp_rsp_ready,
      input  snp_req_ready, ary_rd_en, ary_idx, ary_wr_st_en, ary_wr_st,
      input  snp_rsp_valid, snp_rsp, snp_rsp_dirty, snp_rsp_data
   );

endinterface
`default_nettype wire

// File: rtl/fsm_snp_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_snp_req_ctrl
//  Description : Combinational MESI snoop decode. Given hit, the current block
//                state and the snoop op, produces the next block state and
//                the bus response.
//                i_hit    : tag match on a valid block
//                i_op     : snoop op (SUREQ_*)
//                i_cur_st : current block state (INVALID on a miss)
//                o_nxt_st : state the block moves to
//                o_rsp    : SDRSP_OKAY on hit, SDRSP_INV on miss
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_snp_req_ctrl
   import cache_pkg::*;
(
   input  logic       i_hit,
   input  logic [1:0] i_op,
   input  logic [2:0] i_cur_st,
   output logic [2:0] o_nxt_st,
   output logic [1:0] o_rsp
);

   always_comb begin
      o_nxt_st = i_cur_st;
      o_rsp    = i_hit ? SDRSP_OKAY : SDRSP_INV;
      if (i_hit) begin
         case (i_op)
            // Another reader: any valid copy degrades to SHARED.
            SUREQ_RD:  o_nxt_st = SHARED;
            // Another writer takes ownership: drop our copy.
            SUREQ_RFO: o_nxt_st = INVALID;
            SUREQ_INV: o_nxt_st = INVALID;
            default:   o_nxt_st = i_cur_st;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/snp_req_handler.sv
`default_nettype none
// ============================================================================
//  Module      : snp_req_handler
//  Description : Bus-side snoop request front end of the L1 cache controller.
//                Accepts one snoop at a time, reads tag/state/data of the
//                indexed set, resolves hit/miss, writes back the new block
//                state and returns the snoop response (with dirty data when
//                the block was MODIFIED).
//                clk : rising-edge clock
//                rst : asynchronous active-high reset
//                bus : snp_req_handler_if.slave (request, array, response)
//  Revision    : 1.0 - initial release
// ============================================================================
module snp_req_handler
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int IDX_WIDTH  = 6
) (
   input  logic                clk,
   input  logic                rst,
   snp_req_handler_if.slave    bus
);

   localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);
   localparam int TAG_WIDTH = ADDR_WIDTH - IDX_WIDTH - OFF_WIDTH;

   snp_hdl_st_e           r_state;
   logic [1:0]            r_op;
   logic [TAG_WIDTH-1:0]  r_tag;
   logic [IDX_WIDTH-1:0]  r_idx;
   logic                  r_rd_en;
   logic                  r_rsp_valid;
   logic [1:0]            r_rsp;
   logic                  r_dirty;
   logic [DATA_WIDTH-1:0] r_data;

   logic                  w_req_ready;
   logic                  w_hit;
   logic                  w_rsvd;
   logic [2:0]            w_cur_st;
   logic [2:0]            w_nxt_st;
   logic [1:0]            w_rsp;
   logic                  w_dirty;
   logic                  w_wr_en;
   logic                  w_unused_off;

   // Byte offset within the block is irrelevant to a block snoop.
   assign w_unused_off = ^bus.snp_req_addr[OFF_WIDTH-1:0];

   assign w_req_ready = (r_state == ST_IDLE) && !bus.blk_lock;
   assign w_rsvd      = op_is_rsvd(r_op);

   // Array read data is only meaningful in CMP; the decode is qualified there.
   assign w_hit    = (bus.ary_rd_tag == r_tag) && (bus.ary_rd_st != INVALID);
   assign w_cur_st = w_hit ? bus.ary_rd_st : INVALID;
   assign w_dirty  = w_hit && (w_cur_st == MODIFIED) && !w_rsvd;
   assign w_wr_en  = (r_state == ST_CMP) && w_hit && !w_rsvd && (w_nxt_st != w_cur_st);

   fsm_snp_req_ctrl u_ctrl (
      .i_hit    (w_hit),
      .i_op     (r_op),
      .i_cur_st (w_cur_st),
      .o_nxt_st (w_nxt_st),
      .o_rsp    (w_rsp)
   );

   // ready is gated by rst so it reads 0 for the whole reset pulse.
   assign bus.snp_req_ready = w_req_ready && !rst;
   assign bus.ary_rd_en     = r_rd_en;
   assign bus.ary_idx       = r_idx;
   // The state write must land in the CMP cycle itself, so it is decoded
   // straight from the array read data rather than registered.
   assign bus.ary_wr_st_en  = w_wr_en;
   assign bus.ary_wr_st     = w_wr_en ? w_nxt_st : INVALID;
   assign bus.snp_rsp_valid = r_rsp_valid;
   assign bus.snp_rsp       = r_rsp;
   assign bus.snp_rsp_dirty = r_dirty;
   assign bus.snp_rsp_data  = r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_tag       <= '0;
         r_idx       <= '0;
         r_rd_en     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
         r_dirty     <= 1'b0;
         r_data      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.snp_req_valid && w_req_ready) begin
                  r_op    <= bus.snp_req_op;
                  r_tag   <= bus.snp_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                  r_idx   <= bus.snp_req_addr[OFF_WIDTH +: IDX_WIDTH];
                  r_rd_en <= 1'b1;
                  r_state <= ST_RD;
               end
            end
            ST_RD: begin
               r_rd_en <= 1'b0;
               r_state <= ST_CMP;
            end
            ST_CMP: begin
               r_rsp       <= w_rsp;
               r_dirty     <= w_dirty;
               r_data      <= w_dirty ? bus.ary_rd_data : '0;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RSP;
            end
            ST_RSP: begin
               if (bus.snp_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp       <= '0;
                  r_dirty     <= 1'b0;
                  r_data      <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snp_req_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snp_req_handler
//  Description : Self-checking bench for snp_req_handler. A behavioural array
//                model answers reads one cycle after ary_rd_en; a MESI
//                reference model predicts state writes and responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snp_req_handler;

   localparam int AW = 32;
   localparam int DW = 512;
   localparam int IW = 6;
   localparam int TW = 20;

   // Encodings as the bus and array define them.
   localparam logic [2:0] S_I = 3'd0, S_S = 3'd1, S_E = 3'd2, S_M = 3'd3;
   localparam logic [1:0] OP_RD = 2'd0, OP_RFO = 2'd1, OP_INV = 2'd2, OP_RSV = 2'd3;
   localparam logic [1:0] R_OKAY = 2'd0, R_INV = 2'd1;

   logic clk = 1'b0;
   logic rst;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   wr_cnt   = 0;

   logic [TW-1:0] m_tag  [64];
   logic [2:0]    m_st   [64];
   logic [DW-1:0] m_data [64];

   always #5 clk = ~clk;

   snp_req_handler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

   snp_req_handler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Array model: read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (rst) begin
         bus.ary_rd_tag  <= '0;
         bus.ary_rd_st   <= '0;
         bus.ary_rd_data <= '0;
      end else if (bus.ary_rd_en) begin
         bus.ary_rd_tag  <= m_tag[bus.ary_idx];
         bus.ary_rd_st   <= m_st[bus.ary_idx];
         bus.ary_rd_data <= m_data[bus.ary_idx];
      end
   end

   always @(posedge clk) if (!rst && bus.ary_wr_st_en) wr_cnt <= wr_cnt + 1;

   // MESI snoop rules.
   function automatic void ref_snoop(input logic [1:0] op, input logic [2:0] st,
                                     input bit tag_eq, input logic [DW-1:0] d,
                                     output bit wr, output logic [2:0] nst,
                                     output logic [1:0] rsp, output bit dirty,
                                     output logic [DW-1:0] data);
      bit hit;
      hit = tag_eq && (st != S_I);
      rsp = hit ? R_OKAY : R_INV;
      nst = st;
      if (hit && op == OP_RD) nst = S_S;
      if (hit && (op == OP_RFO || op == OP_INV)) nst = S_I;
      wr    = hit && (op != OP_RSV) && (nst != st);
      dirty = hit && (st == S_M) && (op != OP_RSV);
      data  = dirty ? d : '0;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      return d;
   endfunction

   // One complete snoop; hold = number of RSP cycles with snp_rsp_ready low.
   task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr,
                          input int hold, input string nm);
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
      bit            e_wr, e_dirty;
      logic [2:0]    e_nst;
      logic [1:0]    e_rsp;
      logic [DW-1:0] e_data;
      int            wr_before, n;
      idx = addr[11:6];
      tag = addr[31:12];
      ref_snoop(op, m_st[idx], m_tag[idx] == tag, m_data[idx], e_wr, e_nst, e_rsp, e_dirty, e_data);
      wr_before = wr_cnt;
      bus.snp_req_valid = 1'b1;
      bus.snp_req_op    = op;
      bus.snp_req_addr  = addr;
      #1;
      n = 0;
      while (!bus.snp_req_ready && n < 20) begin @(negedge clk); #1; n++; end
      chk_cnt++;
      if (bus.snp_req_ready !== 1'b1) begin
         $display("FAIL %s accept: ready=%b required 1", nm, bus.snp_req_ready);
         bus.snp_req_valid = 1'b0;
         return;
      end else pass_cnt++;
      @(posedge clk);                       // T: accept
      @(negedge clk);                       // T+1: RD
      bus.snp_req_valid = 1'b0;
      chk_cnt++;
      if ({bus.ary_rd_en, bus.ary_idx, bus.snp_req_ready} !== {1'b1, idx, 1'b0})
         $display("FAIL %s rd: en/idx/ready=%b/%h/%b required 1/%h/0", nm, bus.ary_rd_en, bus.ary_idx, bus.snp_req_ready, idx);
      else pass_cnt++;
      @(negedge clk);                       // T+2: CMP
      chk_cnt++;
      if ({bus.ary_wr_st_en, bus.ary_rd_en, bus.snp_rsp_valid} !== {e_wr, 2'b00})
         $display("FAIL %s wr_en: wr/rd/rspv=%b/%b/%b required %b/0/0", nm, bus.ary_wr_st_en, bus.ary_rd_en, bus.snp_rsp_valid, e_wr);
      else pass_cnt++;
      if (e_wr) begin
         chk_cnt++;
         if (bus.ary_wr_st !== e_nst || bus.ary_idx !== idx)
            $display("FAIL %s wr_st: st/idx=%0d/%h required %0d/%h", nm, bus.ary_wr_st, bus.ary_idx, e_nst, idx);
         else pass_cnt++;
      end
      if (hold > 0) bus.snp_rsp_ready = 1'b0;
      @(negedge clk);                       // T+3: RSP
      for (int i = 0; i <= hold; i++) begin
         chk_cnt++;
         if ({bus.snp_rsp_valid, bus.snp_rsp, bus.snp_rsp_dirty, bus.snp_req_ready} !== {1'b1, e_rsp, e_dirty, 1'b0})
            $display("FAIL %s rsp[%0d]: valid/rsp/dirty/ready=%b/%0d/%b/%b required 1/%0d/%b/0", nm, i,
                     bus.snp_rsp_valid, bus.snp_rsp, bus.snp_rsp_dirty, bus.snp_req_ready, e_rsp, e_dirty);
         else pass_cnt++;
         chk_cnt++;
         if (bus.snp_rsp_data !== e_data)
            $display("FAIL %s data[%0d]: got %h required %h", nm, i, bus.snp_rsp_data, e_data);
         else pass_cnt++;
         if (i < hold) begin
            // A competing request must not be taken while the response waits.
            bus.snp_req_valid = 1'b1;
            bus.snp_req_addr  = addr ^ 32'h0000_5000;
            @(negedge clk);
         end
      end
      bus.snp_req_valid = 1'b0;
      bus.snp_rsp_ready = 1'b1;
      @(negedge clk);                       // back in IDLE
      chk_cnt++;
      if ({bus.snp_rsp_valid, bus.snp_req_ready, bus.ary_rd_en} !== 3'b010)
         $display("FAIL %s idle: rspv/ready/rd_en=%b/%b/%b required 0/1/0", nm, bus.snp_rsp_valid, bus.snp_req_ready, bus.ary_rd_en);
      else pass_cnt++;
      chk_cnt++;
      if (wr_cnt - wr_before !== int'(e_wr))
         $display("FAIL %s wr_count: got %0d required %0d", nm, wr_cnt - wr_before, int'(e_wr));
      else pass_cnt++;
      if (e_wr) m_st[idx] = e_nst;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.snp_req_valid = 1'b1;
      #2;
      chk_cnt++;
      if ({bus.snp_req_ready, bus.ary_rd_en, bus.ary_idx, bus.ary_wr_st_en, bus.ary_wr_st,
           bus.snp_rsp_valid, bus.snp_rsp, bus.snp_rsp_dirty} !== '0 || bus.snp_rsp_data !== '0)
         $display("FAIL reset: ready=%b rd=%b idx=%h wr=%b rspv=%b rsp=%0d dirty=%b required all 0",
                  bus.snp_req_ready, bus.ary_rd_en, bus.ary_idx, bus.ary_wr_st_en,
                  bus.snp_rsp_valid, bus.snp_rsp, bus.snp_rsp_dirty);
      else pass_cnt++;
      @(negedge clk); @(negedge clk);
      bus.snp_req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_rd_exclusive();
      m_tag[1] = 20'h1; m_st[1] = S_E; m_data[1] = rand_data();
      run_req(OP_RD, 32'h0000_1040, 0, "rd_excl");
   endtask

   task automatic test_rfo_modified();
      m_tag[5] = 20'hABCDE; m_st[5] = S_M; m_data[5] = {64{8'hA5}};
      run_req(OP_RFO, {20'hABCDE, 6'd5, 6'd0}, 0, "rfo_mod");
   endtask

   task automatic test_miss();
      m_tag[9] = 20'h00123; m_st[9] = S_M; m_data[9] = rand_data();
      run_req(OP_RD, {20'h00124, 6'd9, 6'd0}, 0, "miss_tag");
      m_tag[10] = 20'h00077; m_st[10] = S_I; m_data[10] = rand_data();
      run_req(OP_RD, {20'h00077, 6'd10, 6'd3}, 0, "miss_inv");
   endtask

   task automatic test_back_to_back();
      m_tag[20] = 20'h55555; m_st[20] = S_M; m_data[20] = rand_data();
      run_req(OP_RD, {20'h55555, 6'd20, 6'd0}, 5, "stall");
      m_tag[21] = 20'h0BEEF; m_st[21] = S_S; m_data[21] = rand_data();
      run_req(OP_INV, {20'h0BEEF, 6'd21, 6'd0}, 0, "b2b_a");
      run_req(OP_INV, {20'h55555, 6'd20, 6'd0}, 0, "b2b_b");
   endtask

   task automatic test_lock();
      bus.blk_lock = 1'b1;
      bus.snp_req_valid = 1'b1;
      bus.snp_req_addr  = {20'h3C3C3, 6'd30, 6'd0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_cnt++;
         if ({bus.snp_req_ready, bus.ary_rd_en} !== 2'b00)
            $display("FAIL lock[%0d]: ready/rd_en=%b/%b required 0/0", i, bus.snp_req_ready, bus.ary_rd_en);
         else pass_cnt++;
      end
      bus.blk_lock = 1'b0;
      m_tag[30] = 20'h3C3C3; m_st[30] = S_S; m_data[30] = rand_data();
      run_req(OP_RSV, {20'h3C3C3, 6'd30, 6'd0}, 0, "lock_rsvd");
   endtask

   task automatic test_rst_mid();
      m_tag[40] = 20'h12345; m_st[40] = S_E; m_data[40] = rand_data();
      bus.snp_req_valid = 1'b1;
      bus.snp_req_op    = OP_RFO;
      bus.snp_req_addr  = {20'h12345, 6'd40, 6'd0};
      @(posedge clk);
      @(negedge clk);
      bus.snp_req_valid = 1'b0;
      @(negedge clk);                       // CMP
      chk_cnt++;
      if (bus.ary_wr_st_en !== 1'b1)
         $display("FAIL rst_mid cmp: wr_en=%b required 1", bus.ary_wr_st_en);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++;
      if ({bus.ary_wr_st_en, bus.ary_wr_st, bus.ary_rd_en, bus.ary_idx, bus.snp_req_ready, bus.snp_rsp_valid} !== '0)
         $display("FAIL rst_mid outs: wr=%b st=%0d rd=%b idx=%h ready=%b rspv=%b required 0",
                  bus.ary_wr_st_en, bus.ary_wr_st, bus.ary_rd_en, bus.ary_idx, bus.snp_req_ready, bus.snp_rsp_valid);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({bus.snp_rsp_valid, bus.snp_req_ready, wr_cnt} !== {2'b01, 32'(wr_cnt)} || bus.snp_rsp_valid !== 1'b0)
         $display("FAIL rst_mid after: rspv/ready=%b/%b required 0/1", bus.snp_rsp_valid, bus.snp_req_ready);
      else pass_cnt++;
      run_req(OP_RFO, {20'h12345, 6'd40, 6'd0}, 0, "rst_reissue");
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         logic [IW-1:0] idx;
         logic [TW-1:0] tag;
         idx = IW'($urandom_range(0, 63));
         tag = TW'($urandom());
         if ($urandom_range(0, 1) == 1) begin
            m_st[idx]   = 3'($urandom_range(0, 3));
            m_data[idx] = rand_data();
         end
         m_tag[idx] = ($urandom_range(0, 3) != 0) ? tag : (tag ^ TW'($urandom_range(1, 255)));
         run_req(2'($urandom_range(0, 3)), {tag, idx, 6'($urandom())},
                 $urandom_range(0, 2), $sformatf("rand%0d", it));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         m_tag[i] = '0; m_st[i] = S_I; m_data[i] = '0;
      end
      rst = 1'b1;
      bus.snp_req_valid = 1'b0;
      bus.snp_req_op    = '0;
      bus.snp_req_addr  = '0;
      bus.blk_lock      = 1'b0;
      bus.snp_rsp_ready = 1'b1;
      test_reset();
      test_rd_exclusive();
      test_rfo_modified();
      test_miss();
      test_back_to_back();
      test_lock();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
